// File: rtl/core_seq_ctrl.sv
// Instruction sequencer for the systolic conv core: per-kij weight/activation/execute/drain, then
// per-onij pmem accumulation. Define CORE_SEQ_STALL_CNT_EN to add the DRAIN stall counter output.
module core_seq_ctrl #(
    parameter int  ROW       = 8,
    parameter int  COL       = 8,
    parameter int  IN_W      = 6,
    parameter int  K_W       = 3,
    parameter int  ADDR_W    = 11,
    parameter int  W_BASE    = 1024,
    localparam int LEN_NIJ   = IN_W * IN_W,
    localparam int LEN_KIJ   = K_W * K_W,
    localparam int OUT_W     = IN_W - K_W + 1,
    localparam int LEN_ONIJ  = OUT_W * OUT_W,
    localparam int ONIJ_W    = (LEN_ONIJ > 1) ? $clog2(LEN_ONIJ) : 1,
    localparam int KIJ_W     = (LEN_KIJ > 1) ? $clog2(LEN_KIJ) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode_in,
    input  logic              ofifo_valid,
    output logic [34:0]       inst,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              out_valid,
    output logic [ONIJ_W-1:0] onij_idx,
    output logic [KIJ_W-1:0]  kij_idx
`ifdef CORE_SEQ_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    localparam int          EXEC_LAST = LEN_NIJ + ROW + COL;
    localparam int          CNT_W     = $clog2(EXEC_LAST + 1);
    localparam int          OR_W      = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int          KR_W      = (K_W > 1) ? $clog2(K_W) : 1;
    localparam logic [34:0] INST_RST  = 35'h1_800C_0000;

    typedef enum logic [3:0] {
        S_IDLE,
        S_KCLR,
        S_WL0,
        S_WLD,
        S_AL0,
        S_EXEC,
        S_DRAIN,
        S_ACLR,
        S_ARD,
        S_AOUT,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [CNT_W-1:0]    r_cnt,  w_cnt_next;
    logic [KIJ_W-1:0]    r_kij,  w_kij_next;
    logic [ONIJ_W-1:0]   r_onij, w_onij_next;
    logic [OR_W-1:0]     r_orow, w_orow_next;
    logic [OR_W-1:0]     r_ocol, w_ocol_next;
    logic [KR_W-1:0]     r_krow, w_krow_next;
    logic [KR_W-1:0]     r_kcol, w_kcol_next;
    logic                r_mode, w_mode_next;

    logic                w_core_rst;
    logic                w_out_valid;
    logic                w_done;
    logic                w_busy;
    logic                w_acc;
    logic                w_cen_p;
    logic                w_wen_p;
    logic [ADDR_W-1:0]   w_a_p;
    logic                w_cen_x;
    logic [ADDR_W-1:0]   w_a_x;
    logic                w_ofifo_rd;
    logic                w_l0_rd;
    logic                w_l0_wr;
    logic                w_exec;
    logic                w_load;
    logic [34:0]         w_inst;

    logic [ADDR_W-1:0]   w_wgt_addr;
    logic [ADDR_W-1:0]   w_drain_addr;
    logic [ADDR_W-1:0]   w_acc_addr;

    assign w_wgt_addr   = ADDR_W'(W_BASE) + ADDR_W'(r_kij) * ADDR_W'(COL) + ADDR_W'(r_cnt);
    assign w_drain_addr = ADDR_W'(r_kij) * ADDR_W'(LEN_NIJ) + ADDR_W'(r_cnt);
    // In ARD the cycle counter doubles as the kernel index k; row/col of o and k are tracked incrementally.
    assign w_acc_addr   = ADDR_W'(r_cnt) * ADDR_W'(LEN_NIJ)
                        + (ADDR_W'(r_orow) + ADDR_W'(r_krow)) * ADDR_W'(IN_W)
                        + ADDR_W'(r_ocol) + ADDR_W'(r_kcol);

    assign w_busy = (r_state != S_IDLE) && (r_state != S_DONE);

    assign w_inst = {r_mode, w_acc, w_cen_p, w_wen_p, w_a_p,
                     w_cen_x, 1'b1, w_a_x,
                     w_ofifo_rd, 2'b00, w_l0_rd, w_l0_wr, w_exec, w_load};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_kij     <= '0;
            r_onij    <= '0;
            r_orow    <= '0;
            r_ocol    <= '0;
            r_krow    <= '0;
            r_kcol    <= '0;
            r_mode    <= 1'b0;
            inst      <= INST_RST;
            core_rst  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            onij_idx  <= '0;
            kij_idx   <= '0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_kij     <= w_kij_next;
            r_onij    <= w_onij_next;
            r_orow    <= w_orow_next;
            r_ocol    <= w_ocol_next;
            r_krow    <= w_krow_next;
            r_kcol    <= w_kcol_next;
            r_mode    <= w_mode_next;
            inst      <= w_inst;
            core_rst  <= w_core_rst;
            busy      <= w_busy;
            done      <= w_done;
            out_valid <= w_out_valid;
            onij_idx  <= r_onij;
            kij_idx   <= r_kij;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_kij_next   = r_kij;
        w_onij_next  = r_onij;
        w_orow_next  = r_orow;
        w_ocol_next  = r_ocol;
        w_krow_next  = r_krow;
        w_kcol_next  = r_kcol;
        w_mode_next  = r_mode;
        w_core_rst   = 1'b0;
        w_out_valid  = 1'b0;
        w_done       = 1'b0;
        w_acc        = 1'b0;
        w_cen_p      = 1'b1;
        w_wen_p      = 1'b1;
        w_a_p        = '0;
        w_cen_x      = 1'b1;
        w_a_x        = '0;
        w_ofifo_rd   = 1'b0;
        w_l0_rd      = 1'b0;
        w_l0_wr      = 1'b0;
        w_exec       = 1'b0;
        w_load       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_KCLR;
                    w_mode_next  = mode_in;
                    w_kij_next   = '0;
                    w_cnt_next   = '0;
                end
            end
            S_KCLR: begin
                w_core_rst   = 1'b1;
                w_cnt_next   = '0;
                w_state_next = S_WL0;
            end
            S_WL0: begin
                w_cen_x = 1'b0;
                w_l0_wr = 1'b1;
                w_a_x   = w_wgt_addr;
                if (r_cnt == CNT_W'(COL - 1)) begin
                    w_cnt_next   = '0;
                    w_state_next = S_WLD;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_WLD: begin
                w_l0_rd = 1'b1;
                w_load  = (r_cnt != '0);
                if (r_cnt == CNT_W'(COL)) begin
                    w_cnt_next   = '0;
                    w_state_next = S_AL0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_AL0: begin
                w_cen_x = 1'b0;
                w_l0_wr = 1'b1;
                w_a_x   = ADDR_W'(r_cnt);
                if (r_cnt == CNT_W'(LEN_NIJ - 1)) begin
                    w_cnt_next   = '0;
                    w_state_next = S_EXEC;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_EXEC: begin
                w_l0_rd = 1'b1;
                w_exec  = (r_cnt != '0);
                if (r_cnt == CNT_W'(EXEC_LAST)) begin
                    w_cnt_next   = '0;
                    w_state_next = S_DRAIN;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_DRAIN: begin
                // r_cnt counts completed beats; a cycle without ofifo_valid is a pure stall.
                if (ofifo_valid) begin
                    w_ofifo_rd = 1'b1;
                    w_cen_p    = 1'b0;
                    w_wen_p    = 1'b0;
                    w_a_p      = w_drain_addr;
                    if (r_cnt == CNT_W'(LEN_NIJ - 1)) begin
                        w_cnt_next = '0;
                        if (r_kij == KIJ_W'(LEN_KIJ - 1)) begin
                            w_onij_next  = '0;
                            w_orow_next  = '0;
                            w_ocol_next  = '0;
                            w_state_next = S_ACLR;
                        end else begin
                            w_kij_next   = r_kij + 1'b1;
                            w_state_next = S_KCLR;
                        end
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
            end
            S_ACLR: begin
                w_core_rst   = 1'b1;
                w_cnt_next   = '0;
                w_krow_next  = '0;
                w_kcol_next  = '0;
                w_state_next = S_ARD;
            end
            S_ARD: begin
                if (r_cnt != CNT_W'(LEN_KIJ)) begin
                    w_cen_p = 1'b0;
                    w_a_p   = w_acc_addr;
                end
                w_acc = (r_cnt != '0);
                if (r_cnt == CNT_W'(LEN_KIJ)) begin
                    w_cnt_next   = '0;
                    w_state_next = S_AOUT;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                    if (r_cnt < CNT_W'(LEN_KIJ - 1)) begin
                        if (r_kcol == KR_W'(K_W - 1)) begin
                            w_kcol_next = '0;
                            w_krow_next = r_krow + 1'b1;
                        end else begin
                            w_kcol_next = r_kcol + 1'b1;
                        end
                    end
                end
            end
            S_AOUT: begin
                w_out_valid = 1'b1;
                if (r_onij == ONIJ_W'(LEN_ONIJ - 1)) begin
                    w_state_next = S_DONE;
                end else begin
                    w_onij_next  = r_onij + 1'b1;
                    w_state_next = S_ACLR;
                    if (r_ocol == OR_W'(OUT_W - 1)) begin
                        w_ocol_next = '0;
                        w_orow_next = r_orow + 1'b1;
                    end else begin
                        w_ocol_next = r_ocol + 1'b1;
                    end
                end
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

`ifdef CORE_SEQ_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_stall_cnt <= '0;
        end else if (r_state == S_DRAIN && !ofifo_valid && r_stall_cnt != 32'hFFFF_FFFF) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
